// File: rtl/nyq_pkg.sv
// Shared constants and state encoding for the polyphase Nyquist decimator sequencer.
package nyq_pkg;

  localparam int DECIM_DEF    = 8;
  localparam int NUM_MACS_DEF = 4;

  // FSM state encoding (IDLE, PRIME, RUN)
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PRIME = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  // Frame counter must be able to hold the value num_macs itself.
  function automatic int fcnt_width(input int num_macs);
    return $clog2(num_macs + 1);
  endfunction

endpackage

// File: rtl/nyq_phase_cnt.sv
// Wrapping polyphase index counter: enable, synchronous clear (priority), terminal-count flag.
module nyq_phase_cnt #(
  parameter  int MOD = 8,
  localparam int W   = $clog2(MOD)
) (
  input  logic         Clk_CI,
  input  logic         Rst_RBI,
  input  logic         En_SI,
  input  logic         Clr_SI,
  output logic [W-1:0] Cnt_DO,
  output logic         Tc_SO
);

  assign Tc_SO = (Cnt_DO == W'(MOD - 1));

  // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      Cnt_DO <= '0;
    end else if (Clr_SI) begin
      Cnt_DO <= '0;
    end else if (En_SI) begin
      Cnt_DO <= Tc_SO ? '0 : Cnt_DO + 1'b1;
    end
  end

endmodule

// File: rtl/nyq_ctrl.sv
// Sequencing controller for the polyphase Nyquist decimation datapath: phase tracking,
// MAC clear/enable, partial-sum shift strobe and decimated output-valid generation.
module nyq_ctrl
  import nyq_pkg::*;
#(
  parameter  int DECIM    = DECIM_DEF,
  parameter  int NUM_MACS = NUM_MACS_DEF,
  localparam int PH_W     = $clog2(DECIM)
) (
  input  logic            Clk_CI,
  input  logic            Rst_RBI,
  input  logic            Run_SI,
  input  logic            In_Valid_SI,
  input  logic            WrEn_SI,
  output logic [PH_W-1:0] Phase_DO,
  output logic            MacEn_SO,
  output logic            MacClr_SO,
  output logic            Shift_SO,
  output logic            Valid_DO,
  output logic            Primed_SO
);

  localparam int FC_W = fcnt_width(NUM_MACS);
  localparam logic [FC_W-1:0] FC_FULL = FC_W'(NUM_MACS);

  logic [1:0]      state_q;
  logic [FC_W-1:0] fcnt_q;
  logic [FC_W-1:0] fcnt_inc;
  logic            shift_q;
  logic            valid_q;
  logic            accepted;
  logic            phase_tc;
  logic            shift_fire;

  // A sample coinciding with a coefficient write is dropped: its coefficients are stale.
  assign accepted   = In_Valid_SI && (state_q != ST_IDLE) && !WrEn_SI;
  assign fcnt_inc   = (fcnt_q == FC_FULL) ? fcnt_q : fcnt_q + 1'b1;

  // Dropping Run_SI cancels a pulse that is already registered, not just future ones.
  assign shift_fire = shift_q && Run_SI;

  nyq_phase_cnt #(
    .MOD (DECIM)
  ) u_phase_cnt (
    .Clk_CI  (Clk_CI),
    .Rst_RBI (Rst_RBI),
    .En_SI   (accepted),
    .Clr_SI  (!Run_SI || WrEn_SI),
    .Cnt_DO  (Phase_DO),
    .Tc_SO   (phase_tc)
  );

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q <= ST_IDLE;
      fcnt_q  <= '0;
      shift_q <= 1'b0;
      valid_q <= 1'b0;
    end else if (!Run_SI) begin
      state_q <= ST_IDLE;
      fcnt_q  <= '0;
      shift_q <= 1'b0;
      valid_q <= 1'b0;
    end else if (state_q == ST_IDLE) begin
      state_q <= ST_PRIME;
      shift_q <= 1'b0;
      valid_q <= 1'b0;
    end else if (WrEn_SI) begin
      // A shift firing this cycle still leaves, but it cannot complete a coherent frame.
      state_q <= ST_PRIME;
      fcnt_q  <= '0;
      shift_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      shift_q <= accepted && phase_tc;
      valid_q <= shift_fire && (fcnt_inc == FC_FULL);
      if (shift_fire) begin
        fcnt_q <= fcnt_inc;
        if (fcnt_inc == FC_FULL) state_q <= ST_RUN;
      end
    end
  end

  assign MacEn_SO  = accepted;
  assign MacClr_SO = accepted && (Phase_DO == '0);
  assign Shift_SO  = shift_fire;
  assign Valid_DO  = valid_q && Run_SI;
  assign Primed_SO = (state_q == ST_RUN);

endmodule
